// File: rtl/base_fifo_ctl_if.sv
// rtl/base_fifo_ctl_if.sv - valid/ready handshake bundle for base_fifo_ctl
interface base_fifo_ctl_if #(
    parameter int width = 8
);
    logic             i_v;
    logic             i_r;
    logic [width-1:0] i_d;
    logic             o_v;
    logic             o_r;
    logic [width-1:0] o_d;

    // slave is the FIFO's view; master is the producer/consumer side
    modport slave  (input  i_v, i_d, o_r, output i_r, o_v, o_d);
    modport master (output i_v, i_d, o_r, input  i_r, o_v, o_d);
endinterface

// File: rtl/base_fifo_ctl.sv
// rtl/base_fifo_ctl.sv - valid/ready FIFO with count, almost flags and flush
module base_fifo_ctl #(
    parameter int    width      = 8,
    parameter int    DEPTH      = 8,
    parameter int    LOG_DEPTH  = $clog2(DEPTH),
    parameter int    output_reg = 0,
    parameter int    CAP        = DEPTH + 1 + output_reg,
    parameter int    CNT_W      = $clog2(CAP + 1),
    parameter int    AFULL_TH   = DEPTH - 2,
    parameter int    AEMPTY_TH  = 1,
    parameter string ramstyle   = "no_rw_check"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    base_fifo_ctl_if.slave   bus,
    output logic [CNT_W-1:0] count,
    output logic             afull,
    output logic             aempty
);
    if (DEPTH < 2 || AFULL_TH > CAP || AEMPTY_TH >= CAP) begin : g_param_err
        $error("base_fifo_ctl: illegal DEPTH/AFULL_TH/AEMPTY_TH");
    end

    (* ramstyle = ramstyle *) logic [width-1:0] mem [DEPTH];

    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic                 ram_full, ram_empty;
    logic                 in_xfer, out_xfer, ram_rd, rd_drain;
    logic                 rd_v;
    logic [width-1:0]     rd_d;
    logic [CNT_W-1:0]     count_nx;

    assign bus.i_r   = ~ram_full & ~flush;
    assign in_xfer   = bus.i_v & bus.i_r;
    assign out_xfer  = bus.o_v & bus.o_r;
    assign ram_rd    = ~ram_empty & (~rd_v | rd_drain);
    assign wr_ptr_nx = (wr_ptr == LOG_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_nx = (rd_ptr == LOG_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign count_nx  = count + CNT_W'(in_xfer) - CNT_W'(out_xfer);

    always_ff @(posedge clk) begin
        if (in_xfer) mem[wr_ptr] <= bus.i_d;
    end

    always_ff @(posedge clk) begin
        if (ram_rd) rd_d <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_full  <= 1'b0;
            ram_empty <= 1'b1;
            rd_v      <= 1'b0;
            count     <= '0;
            afull     <= (AFULL_TH <= 0);
            aempty    <= 1'b1;
        end else begin
            if (in_xfer) wr_ptr <= wr_ptr_nx;
            if (ram_rd)  rd_ptr <= rd_ptr_nx;
            // simultaneous write and read leaves RAM occupancy unchanged
            if (in_xfer && !ram_rd) begin
                ram_empty <= 1'b0;
                ram_full  <= (wr_ptr_nx == rd_ptr);
            end else if (!in_xfer && ram_rd) begin
                ram_full  <= 1'b0;
                ram_empty <= (rd_ptr_nx == wr_ptr);
            end
            if (ram_rd)        rd_v <= 1'b1;
            else if (rd_drain) rd_v <= 1'b0;
            count  <= count_nx;
            afull  <= (count_nx >= CNT_W'(AFULL_TH));
            aempty <= (count_nx <= CNT_W'(AEMPTY_TH));
        end
    end

    if (output_reg != 0) begin : g_oreg
        logic             oq_v;
        logic [width-1:0] oq_d;

        assign rd_drain = rd_v & (~oq_v | out_xfer);
        assign bus.o_v  = oq_v & ~flush;
        assign bus.o_d  = oq_d;

        always_ff @(posedge clk) begin
            if (reset || flush) oq_v <= 1'b0;
            else if (rd_drain)  oq_v <= 1'b1;
            else if (out_xfer)  oq_v <= 1'b0;
        end

        always_ff @(posedge clk) begin
            if (rd_drain) oq_d <= rd_d;
        end
    end else begin : g_direct
        assign rd_drain = out_xfer;
        assign bus.o_v  = rd_v & ~flush;
        assign bus.o_d  = rd_d;
    end
endmodule
